// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: ROM fetch port, redirect request and decode handshake of the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 2
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic                  fetch_enable;
  logic [DATA_WIDTH-1:0] rom_address;
  logic [DATA_WIDTH-1:0] rom_instruction;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_out;
  logic [DATA_WIDTH-1:0] instr_pc;
  logic [DATA_WIDTH-1:0] instr_pc_plus4;
  logic [CW-1:0]         queue_count;
  modport master (
    input  fetch_enable, rom_instruction, redirect_valid, redirect_pc, instr_ready,
    output rom_address, instr_valid, instr_out, instr_pc, instr_pc_plus4, queue_count
  );
  modport slave (
    output fetch_enable, rom_instruction, redirect_valid, redirect_pc, instr_ready,
    input  rom_address, instr_valid, instr_out, instr_pc, instr_pc_plus4, queue_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC, queues ROM words with their PCs and hands them to decode.
module fetch_sequencer #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    QUEUE_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input logic clk,
  input logic reset,
  fetch_sequencer_if.master bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] pc_mem  [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] ins_mem [QUEUE_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;
  logic                  empty, pop, push;
  always_comb begin
    empty = count == '0;
    pop   = ~empty & bus.instr_ready;
    push  = bus.fetch_enable & ~bus.redirect_valid & ((count < CW'(QUEUE_DEPTH)) | pop);
  end
  // Head is read straight out of the queue registers, so rom_instruction never reaches decode combinationally.
  assign bus.rom_address    = fetch_pc;
  assign bus.instr_valid    = ~empty;
  assign bus.instr_out      = empty ? '0 : ins_mem[rd_ptr];
  assign bus.instr_pc       = empty ? '0 : pc_mem[rd_ptr];
  assign bus.instr_pc_plus4 = empty ? '0 : pc_mem[rd_ptr] + DATA_WIDTH'(4);
  assign bus.queue_count    = count;
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[DATA_WIDTH-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]  <= fetch_pc;
        ins_mem[wr_ptr] <= bus.rom_instruction;
        wr_ptr          <= wr_ptr + AW'(1);
        fetch_pc        <= fetch_pc + DATA_WIDTH'(4);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed test-plan sequences plus random traffic against a queue-based reference model.
module tb_fetch_sequencer;
  logic clk = 0;
  logic reset, reset2;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.DATA_WIDTH(32), .QUEUE_DEPTH(2)) bus ();
  fetch_sequencer_if #(.DATA_WIDTH(32), .QUEUE_DEPTH(2)) bus2 ();

  fetch_sequencer #(.DATA_WIDTH(32), .QUEUE_DEPTH(2), .RESET_PC(32'h0000_0000))
    dut (.clk(clk), .reset(reset), .bus(bus));
  fetch_sequencer #(.DATA_WIDTH(32), .QUEUE_DEPTH(2), .RESET_PC(32'hFFFF_FFF8))
    dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb bus.rom_instruction  = rom_f(bus.rom_address);
  always_comb bus2.rom_instruction = rom_f(bus2.rom_address);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] mpc;
  bit          armed = 0;

  always @(posedge clk) begin
    bit p, u;
    if (reset) begin
      mq.delete();
      mpc   = 32'h0;
      armed = 1;
    end else if (armed) begin
      if (bus.redirect_valid) begin
        mq.delete();
        mpc = bus.redirect_pc & 32'hFFFF_FFFC;
      end else begin
        p = (mq.size() > 0) && bus.instr_ready;
        u = bus.fetch_enable && (mq.size() < 2 || p);
        if (p) void'(mq.pop_front());
        if (u) begin
          mq.push_back('{pc: mpc, ins: rom_f(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, mq.size() != 0});
      chk("queue_count", {30'b0, bus.queue_count}, mq.size());
      chk("rom_address", bus.rom_address, mpc);
      chk("instr_out", bus.instr_out, mq.size() != 0 ? mq[0].ins : 32'h0);
      chk("instr_pc", bus.instr_pc, mq.size() != 0 ? mq[0].pc : 32'h0);
      chk("instr_pc_plus4", bus.instr_pc_plus4, mq.size() != 0 ? mq[0].pc + 32'd4 : 32'h0);
    end
  end

  initial begin
    reset2 = 1;
    bus2.fetch_enable = 1;
    bus2.instr_ready = 1;
    bus2.redirect_valid = 0;
    bus2.redirect_pc = 0;
    step();
    step();
    reset2 = 0;
    chk("wrap_empty", {31'b0, bus2.instr_valid}, 32'h0);
    chk("wrap_rom0", bus2.rom_address, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc0", bus2.instr_pc, 32'hFFFF_FFF8);
    chk("wrap_out0", bus2.instr_out, 32'hFFF8_0007);
    chk("wrap_p4_0", bus2.instr_pc_plus4, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc1", bus2.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_p4_1", bus2.instr_pc_plus4, 32'h0000_0000);
    step();
    chk("wrap_pc2", bus2.instr_pc, 32'h0000_0000);
    chk("wrap_out2", bus2.instr_out, 32'h0000_FFFF);
  end

  initial begin
    logic [31:0] exp_w [4] = '{32'h0000_FFFF, 32'h0004_FFFB, 32'h0008_FFF7, 32'h000C_FFF3};
    reset = 1;
    bus.fetch_enable = 0;
    bus.instr_ready = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    step();
    step();
    reset = 0;
    bus.fetch_enable = 1;
    bus.instr_ready = 1;
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst_rom", bus.rom_address, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_out", bus.instr_out, exp_w[i]);
      chk("stream_pc", bus.instr_pc, 32'(4 * i));
      chk("stream_p4", bus.instr_pc_plus4, 32'(4 * i + 4));
    end
    reset = 1;
    step();
    reset = 0;
    bus.instr_ready = 0;
    step();
    chk("stall_cnt1", {30'b0, bus.queue_count}, 32'd1);
    step();
    chk("stall_cnt2", {30'b0, bus.queue_count}, 32'd2);
    step();
    step();
    chk("stall_rom", bus.rom_address, 32'h8);
    chk("stall_head", bus.instr_out, exp_w[0]);
    bus.instr_ready = 1;
    step();
    chk("full_pop_cnt", {30'b0, bus.queue_count}, 32'd2);
    chk("full_pop_head", bus.instr_out, exp_w[1]);
    chk("full_pop_rom", bus.rom_address, 32'hC);
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h0000_0023;
    step();
    bus.redirect_valid = 0;
    chk("redir_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("redir_cnt", {30'b0, bus.queue_count}, 32'd0);
    chk("redir_rom", bus.rom_address, 32'h20);
    step();
    chk("redir_pc", bus.instr_pc, 32'h20);
    chk("redir_out", bus.instr_out, 32'h0020_FFDF);
    bus.instr_ready = 0;
    step();
    bus.fetch_enable = 0;
    bus.instr_ready = 1;
    step();
    step();
    chk("drain_cnt", {30'b0, bus.queue_count}, 32'd0);
    chk("drain_rom", bus.rom_address, 32'h28);
    bus.fetch_enable = 1;
    bus.instr_ready = 0;
    step();
    step();
    bus.fetch_enable = 0;
    step();
    chk("pre_rst_cnt", {30'b0, bus.queue_count}, 32'd2);
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("mid_rst_cnt", {30'b0, bus.queue_count}, 32'd0);
    chk("mid_rst_rom", bus.rom_address, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 99) == 0;
      bus.fetch_enable = $urandom_range(0, 4) != 0;
      bus.instr_ready = $urandom_range(0, 4) < 3;
      bus.redirect_valid = $urandom_range(0, 19) == 0;
      bus.redirect_pc = $urandom;
      step();
    end
    reset = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
